crc32: RTL and testbench
========================

CRC32 -- requirements
Module: crc32

Interface
REQ-001 Parameter POLY, default 32'hEDB88320, reflected CRC-32 (IEEE 802.3) polynomial.
REQ-002 Parameter INIT, default 32'hFFFFFFFF, value loaded into the CRC state register by reset.
REQ-003 Parameter XOROUT, default 32'hFFFFFFFF, value XORed with the state register to form crc.
REQ-004 c  input  1  clock; all state changes on rising edge.
REQ-005 r  input  1  reset, asynchronous, active-low.
REQ-006 dv  input  1  data valid; d is consumed on each rising edge of c where dv=1.
REQ-007 d  input  8  data byte, processed LSB first (reflected input).
REQ-008 crc  output  32  running CRC result, equal to state XOR XOROUT, reflected output.

Function
REQ-009 The block SHALL hold a 32-bit state register S.
REQ-010 On a rising edge of c with dv=1, S SHALL become the byte-wise update of S with d.
- Per bit i=0..7: fb = S[0] ^ d[i]; S = (S >> 1) ^ (fb ? POLY : 0).
- All 8 bit steps SHALL be combinational within one clock, giving one byte per cycle.
REQ-011 On a rising edge with dv=0, S SHALL hold its value.
REQ-012 crc SHALL be the combinational function S ^ XOROUT, with no extra register stage.
REQ-013 Latency SHALL be one cycle: the byte sampled at edge N is reflected in crc immediately after edge N.
REQ-014 Back-to-back dv=1 cycles SHALL be accepted every cycle, with no throughput gaps and no ready/backpressure signal.
REQ-015 There SHALL be no length limit; S wraps naturally as a 32-bit value.
REQ-016 X/Z on d while dv=0 SHALL NOT affect S.

Reset
REQ-017 While r=0, S SHALL equal INIT regardless of c, dv and d, so crc=32'h00000000 at the defaults.
REQ-018 Asserting r mid-stream SHALL discard the partial CRC immediately, without waiting for a clock edge.
REQ-019 On the first rising edge after r deasserts, if dv=1, that byte SHALL be processed from S=INIT.
REQ-020 No other state exists; there are no sticky flags and no counters.

Structure
REQ-021 A shared package crc_pkg SHALL hold the constants CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_XOROUT=32'hFFFFFFFF, CRC32_CHECK=32'hCBF43926.
REQ-022 The package SHALL also hold the pure function crc32_next_byte(state[31:0], byte[7:0]) returning the next state, reused by the RTL and by the scoreboard model.
REQ-023 The combinational byte-update SHALL be one natural sub-module, crc32_byte_step (inputs s_in[31:0] and d[7:0], output s_out[31:0]), instantiated once.
REQ-024 Simulation clock helper sim_clk SHALL provide a parameter for frequency in MHz (default 100, i.e. a 10 ns period, 50 % duty) and output c.
REQ-025 sim_clk is simulation-only and SHALL NOT be synthesized.

Verification
REQ-026 r=0 for 3 cycles, then released with dv=0 -> crc=32'h00000000, stable over 3 idle cycles.
REQ-027 After reset, one byte 8'h00 with dv=1 -> crc=32'hD202EF8D; the value is held after dv drops.
REQ-028 After reset, one byte 8'hFF -> crc=32'hFF000000.
REQ-029 After reset, ASCII "123456789" (8'h31..8'h39) on consecutive cycles -> crc=32'hCBF43926.
REQ-030 Same "123456789" stream with dv=0 gaps of random length inserted, and d randomized during the gaps -> crc=32'hCBF43926.
REQ-031 Reset mid-stream:
- Stimulus: feed 8'h31,8'h32; pulse r=0 asynchronously between edges; then feed "123456789".
- Response: crc=0 during the pulse, and the final crc=32'hCBF43926.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-32 constants and the byte-wise state update used by the RTL
// and by any software-style model that needs the same arithmetic.
`timescale 1ns/1ps
package crc_pkg;

  // Reflected IEEE 802.3 polynomial, initial state, output XOR and the
  // well-known check value for the ASCII string "123456789".
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_CHECK     = 32'hCBF43926;

  // Advance a reflected CRC state by one byte, consuming the LSB first.
  // The polynomial defaults to the IEEE one but can be overridden so the
  // parameterised datapath stays consistent with this single definition.
  function automatic logic [31:0] crc32_next_byte(
    input logic [31:0] state,
    input logic [7:0]  byte_in,
    input logic [31:0] poly = CRC32_POLY_REFL
  );
    logic [31:0] s;
    logic        fb;
    s = state;
    for (int i = 0; i < 8; i++) begin
      fb = s[0] ^ byte_in[i];
      s  = (s >> 1) ^ (fb ? poly : 32'h0000_0000);
    end
    return s;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Purely combinational one-byte CRC-32 update: all eight bit steps are
// unrolled so a full byte is absorbed in a single clock cycle.
`timescale 1ns/1ps
module crc32_byte_step
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY_REFL
) (
  input  logic [31:0] s_in,
  input  logic [7:0]  d,
  output logic [31:0] s_out
);

  logic [31:0] w_next;

  // Unrolled byte update; the loop inside the function flattens to XOR trees.
  always_comb begin
    w_next = crc32_next_byte(s_in, d, POLY);
  end

  assign s_out = w_next;

endmodule

// File: rtl/crc32.sv
// Streaming CRC-32 engine: absorbs one byte per cycle whenever dv is high,
// exposes the running result combinationally from the state register.
`timescale 1ns/1ps
module crc32
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY   = CRC32_POLY_REFL,
  parameter logic [31:0] INIT   = CRC32_INIT,
  parameter logic [31:0] XOROUT = CRC32_XOROUT
) (
  input  logic        c,
  input  logic        r,
  input  logic        dv,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] r_state;
  logic [31:0] w_next;

  crc32_byte_step #(
    .POLY (POLY)
  ) u_step (
    .s_in  (r_state),
    .d     (d),
    .s_out (w_next)
  );

  // State register: reset forces INIT immediately; a valid byte advances it,
  // otherwise it holds so d is ignored (including X/Z) while dv is low.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      r_state <= INIT;
    end else if (dv) begin
      r_state <= w_next;
    end
  end

  assign crc = r_state ^ XOROUT;

endmodule

// File: tb/tb_crc32.sv
// Self-checking bench for crc32 with a table-driven reference model over the
// whole message received since the last reset.
`timescale 1ns/1ps

// Simulation-only free-running clock source.
module sim_clk #(
  parameter real FREQ_MHZ = 100.0
) (
  output logic c
);
  localparam real HALF_NS = 500.0 / FREQ_MHZ;

  // Square wave, 50 % duty, starting low.
  always begin
    c = 1'b0;
    #(HALF_NS);
    c = 1'b1;
    #(HALF_NS);
  end
endmodule

module tb_crc32;
  import crc_pkg::*;

  logic        clock;
  logic        r;
  logic        dv;
  logic [7:0]  d;
  logic [31:0] crc;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0]  msg[$];
  logic [31:0] crcTable[256];

  sim_clk #(.FREQ_MHZ(100.0)) u_clk (.c(clock));

  crc32 dut (
    .c   (clock),
    .r   (r),
    .dv  (dv),
    .d   (d),
    .crc (crc)
  );

  // Compare one observed value against its expectation and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Build the classic 256-entry lookup table for the reflected polynomial.
  task automatic buildTable();
    logic [31:0] v;
    for (int n = 0; n < 256; n++) begin
      v = 32'(n);
      for (int k = 0; k < 8; k++)
        v = v[0] ? ((v >> 1) ^ CRC32_POLY_REFL) : (v >> 1);
      crcTable[n] = v;
    end
  endtask

  // Reference CRC of every byte accepted since the last reset.
  function automatic logic [31:0] refCrc();
    logic [31:0] acc;
    acc = CRC32_INIT;
    foreach (msg[i])
      acc = crcTable[(acc ^ {24'h0, msg[i]}) & 32'hFF] ^ (acc >> 8);
    return acc ^ CRC32_XOROUT;
  endfunction

  // Drive one cycle of input on the falling edge; log accepted bytes.
  task automatic applyStimulus(input logic v, input logic [7:0] b);
    @(negedge clock);
    dv = v;
    d  = b;
    @(posedge clock);
    #1;
    if (v && r) msg.push_back(b);
  endtask

  // Hold reset for some cycles, checking the cleared output throughout.
  task automatic doReset(input int cycles);
    @(negedge clock);
    r  = 1'b0;
    dv = 1'b0;
    msg.delete();
    #1;
    checkOutput("resetAsync", crc, 32'h0000_0000);
    repeat (cycles) begin
      @(negedge clock);
      checkOutput("resetHold", crc, 32'h0000_0000);
    end
    r = 1'b1;
  endtask

  // Stream "123456789", optionally with random idle gaps carrying junk data.
  task automatic sendCheckString(input bit withGaps);
    int gap;
    for (int ch = 8'h31; ch <= 8'h39; ch++) begin
      applyStimulus(1'b1, 8'(ch));
      checkOutput("checkStrByte", crc, refCrc());
      if (withGaps) begin
        gap = $urandom_range(0, 4);
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, 8'($urandom));
          checkOutput("gapHold", crc, refCrc());
        end
      end
    end
    checkOutput("checkStrFinal", crc, CRC32_CHECK);
  endtask

  initial begin
    int len;
    logic v;
    logic [7:0] b;

    buildTable();
    r  = 1'b0;
    dv = 1'b0;
    d  = 8'h00;
    $display("[TB] crc32 bench start");

    // Power-on reset for 3 cycles, then idle with dv low.
    doReset(3);
    repeat (3) begin
      applyStimulus(1'b0, 8'($urandom));
      checkOutput("idleAfterReset", crc, 32'h0000_0000);
    end

    // Single zero byte, then held while idle.
    applyStimulus(1'b1, 8'h00);
    checkOutput("byte00", crc, 32'hD202EF8D);
    checkOutput("byte00Model", crc, refCrc());
    repeat (2) begin
      applyStimulus(1'b0, 8'($urandom));
      checkOutput("byte00Held", crc, 32'hD202EF8D);
    end

    // Single 0xFF byte.
    doReset(1);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("byteFF", crc, 32'hFF000000);

    // Check string back-to-back, then with random gaps.
    doReset(1);
    sendCheckString(1'b0);
    doReset(1);
    sendCheckString(1'b1);

    // Mid-stream reset pulse between edges, with dv already high on release
    // so the first byte after reset is taken from INIT.
    doReset(1);
    applyStimulus(1'b1, 8'h31);
    applyStimulus(1'b1, 8'h32);
    checkOutput("preMidReset", crc, refCrc());
    #2;
    r  = 1'b0;
    d  = 8'h31;
    dv = 1'b1;
    msg.delete();
    #1;
    checkOutput("midResetAsync", crc, 32'h0000_0000);
    #4;
    r = 1'b1;
    @(posedge clock);
    #1;
    msg.push_back(8'h31);
    checkOutput("firstAfterRelease", crc, refCrc());
    for (int ch = 8'h32; ch <= 8'h39; ch++) begin
      applyStimulus(1'b1, 8'(ch));
      checkOutput("midResetStream", crc, refCrc());
    end
    checkOutput("midResetFinal", crc, CRC32_CHECK);

    // Random messages with random valid patterns against the model.
    for (int m = 0; m < 8; m++) begin
      doReset($urandom_range(0, 2));
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        v = ($urandom_range(0, 3) != 0);
        b = 8'($urandom);
        applyStimulus(v, b);
        checkOutput("randomStream", crc, refCrc());
      end
    end

    @(negedge clock);
    dv = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    errorCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
